// File: rtl/nibble_sbox_decrypt.sv
`default_nettype none
// ============================================================================
// Module   : nibble_sbox_decrypt
// Brief    : Iterative 8-bit nibble-substitution block decryptor, one inverse
//            round per clock, valid/ready handshakes on input and output.
// Revision : 1.0 - initial release
// ============================================================================
module nibble_sbox_decrypt #(
    parameter int ROUNDS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] ciphertext,
    input  logic [7:0] key,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] plaintext,
    output logic       busy
);

    localparam logic [3:0] c_LAST_RND = 4'(ROUNDS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t     state_q;
    logic [7:0] blk_q;
    logic [7:0] key_q;
    logic [3:0] rnd_q;
    logic       in_ready_q;
    logic       out_valid_q;
    logic       busy_q;

    logic [7:0] swap_w;
    logic [7:0] sub_w;
    logic [7:0] rk_w;
    logic [7:0] blk_d;

    function automatic logic [3:0] inv_sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'h5;
            4'h1: y = 4'hE;
            4'h2: y = 4'hF;
            4'h3: y = 4'h8;
            4'h4: y = 4'hC;
            4'h5: y = 4'h1;
            4'h6: y = 4'h2;
            4'h7: y = 4'hD;
            4'h8: y = 4'hB;
            4'h9: y = 4'h4;
            4'hA: y = 4'h6;
            4'hB: y = 4'h3;
            4'hC: y = 4'h0;
            4'hD: y = 4'h7;
            4'hE: y = 4'h9;
            default: y = 4'hA;
        endcase
        return y;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] k, input logic [2:0] amt);
        logic [7:0] y;
        case (amt)
            3'd0: y = k;
            3'd1: y = {k[6:0], k[7]};
            3'd2: y = {k[5:0], k[7:6]};
            3'd3: y = {k[4:0], k[7:5]};
            3'd4: y = {k[3:0], k[7:4]};
            3'd5: y = {k[2:0], k[7:3]};
            3'd6: y = {k[1:0], k[7:2]};
            default: y = {k[0], k[7:1]};
        endcase
        return y;
    endfunction

    // One inverse round: undo the nibble swap, then the S-box, then the key mix.
    always_comb begin
        swap_w = {blk_q[3:0], blk_q[7:4]};
        sub_w  = {inv_sbox(swap_w[7:4]), inv_sbox(swap_w[3:0])};
        rk_w   = rotl8(key_q, rnd_q[2:0]) ^ {4'b0000, rnd_q};
        blk_d  = sub_w ^ rk_w;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            blk_q       <= 8'h00;
            key_q       <= 8'h00;
            rnd_q       <= 4'd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        key_q      <= key;
                        blk_q      <= ciphertext ^ ~key;
                        rnd_q      <= c_LAST_RND;
                        state_q    <= S_RUN;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                S_RUN: begin
                    blk_q <= blk_d;
                    if (rnd_q == 4'd0) begin
                        state_q     <= S_DONE;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                    end else begin
                        rnd_q <= rnd_q - 4'd1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign plaintext = blk_q;

endmodule
`default_nettype wire

// File: tb/tb_nibble_sbox_decrypt.sv
`default_nettype none
// ============================================================================
// Module   : tb_nibble_sbox_decrypt
// Brief    : Self-checking bench; four DUTs (ROUNDS = 1, 4, 8, 15) against a
//            cycle-level behavioural model with brute-force inversion.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nibble_sbox_decrypt;

    localparam int NL  = 4;
    localparam int NTX = 1000;
    localparam logic [63:0] SB_PACK = 64'hC56B90AD3EF84712;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid  [NL];
    logic       in_ready  [NL];
    logic       out_valid [NL];
    logic       out_ready [NL];
    logic       busy      [NL];
    logic [7:0] ct        [NL];
    logic [7:0] ky        [NL];
    logic [7:0] pt        [NL];

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en    = 1'b0;
    bit rand_mode = 1'b0;

    int         m_ph  [NL];
    int         m_cnt [NL];
    logic [7:0] m_pt  [NL];
    logic [7:0] pend_p[NL];

    always #5 clk = ~clk;

    function automatic int rounds_of(input int l);
        case (l)
            0: return 1;
            1: return 4;
            2: return 8;
            default: return 15;
        endcase
    endfunction

    for (genvar g = 0; g < NL; g++) begin : g_dut
        nibble_sbox_decrypt #(
            .ROUNDS((g == 0) ? 1 : (g == 1) ? 4 : (g == 2) ? 8 : 15)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .ciphertext(ct[g]),
            .key       (ky[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .plaintext (pt[g]),
            .busy      (busy[g])
        );
    end

    function automatic logic [3:0] sbf(input logic [3:0] x);
        return SB_PACK[63 - 4 * int'(x) -: 4];
    endfunction

    // Forward cipher straight from its definition; decryption is found by search.
    function automatic logic [7:0] enc(input logic [7:0] p, input logic [7:0] k, input int nr);
        logic [7:0]  s;
        logic [15:0] kk;
        s = p;
        for (int r = 0; r < nr; r++) begin
            kk = {k, k} << (r % 8);
            s  = s ^ (kk[15:8] ^ 8'(r));
            s  = {sbf(s[7:4]), sbf(s[3:0])};
            s  = {s[3:0], s[7:4]};
        end
        return s ^ ~k;
    endfunction

    function automatic logic [7:0] dec_bf(input logic [7:0] c, input logic [7:0] k, input int nr);
        for (int i = 0; i < 256; i++)
            if (enc(8'(i), k, nr) == c) return 8'(i);
        return 8'hXX;
    endfunction

    task automatic check(input string name, input int l, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s lane%0d t=%0t: got %02h, expected %02h", name, l, $time, act, exp);
        end
    endtask

    // Transaction-level model: phase 0 idle, 1 running, 2 result held.
    always @(posedge clk) begin
        for (int l = 0; l < NL; l++) begin
            if (rst) begin
                m_ph[l]  <= 0;
                m_cnt[l] <= 0;
                m_pt[l]  <= 8'h00;
            end else begin
                case (m_ph[l])
                    0: if (in_valid[l]) begin
                        m_ph[l]  <= 1;
                        m_cnt[l] <= rounds_of(l);
                        m_pt[l]  <= dec_bf(ct[l], ky[l], rounds_of(l));
                    end
                    1: begin
                        m_cnt[l] <= m_cnt[l] - 1;
                        if (m_cnt[l] == 1) m_ph[l] <= 2;
                    end
                    default: if (out_ready[l]) m_ph[l] <= 0;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int l = 0; l < NL; l++) begin
                check("in_ready", l, 8'(in_ready[l]), 8'(m_ph[l] == 0));
                check("out_valid", l, 8'(out_valid[l]), 8'(m_ph[l] == 2));
                check("busy", l, 8'(busy[l]), 8'(m_ph[l] == 1));
                if (m_ph[l] != 1) check("plaintext", l, pt[l], m_pt[l]);
                if (rand_mode && m_ph[l] == 2 && out_ready[l])
                    check("roundtrip", l, pt[l], pend_p[l]);
            end
        end
    end

    task automatic lane_random(input int l);
        logic [7:0] p, k;
        int  bound;
        bit  ok;
        for (int n = 0; n < NTX; n++) begin
            p = 8'($urandom);
            k = 8'($urandom);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            pend_p[l]   = p;
            ky[l]       = k;
            ct[l]       = enc(p, k, rounds_of(l));
            in_valid[l] = 1'b1;
            bound = 0;
            ok    = 1'b0;
            while (!ok && bound < 50) begin
                @(negedge clk);
                ok = in_ready[l];
                @(posedge clk);
                #1;
                bound++;
            end
            if (!ok) check("accept_timeout", l, 8'd0, 8'd1);
            in_valid[l] = 1'b0;
            ct[l]       = 8'($urandom);
            ky[l]       = 8'($urandom);
            bound = 0;
            ok    = 1'b0;
            while (!ok && bound < 200) begin
                out_ready[l] = 1'($urandom_range(0, 1));
                @(negedge clk);
                ok = out_valid[l] && out_ready[l];
                @(posedge clk);
                #1;
                bound++;
            end
            out_ready[l] = 1'b0;
            if (!ok) check("output_timeout", l, 8'd0, 8'd1);
        end
    endtask

    initial begin
        logic [7:0] seq [4];
        int  bound;
        bit  ok;
        seq = '{8'hAD, 8'h74, 8'hCC, 8'h00};
        for (int l = 0; l < NL; l++) begin
            in_valid[l]  = 1'b1;
            out_ready[l] = 1'b0;
            ct[l]        = 8'($urandom);
            ky[l]        = 8'($urandom);
            pend_p[l]    = 8'h00;
        end

        check("model_enc_r4", 1, enc(8'h00, 8'h00, 4), 8'hE0);
        check("model_enc_r1", 0, enc(8'h3C, 8'hA5, 1), 8'hB4);
        check("model_dec_r4", 1, dec_bf(8'hE0, 8'h00, 4), 8'h00);

        // Reset held two cycles with in_valid asserted.
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int l = 0; l < NL; l++) in_valid[l] = 1'b0;
        @(posedge clk); #1;

        // Known vectors on lanes 0 (ROUNDS=1) and 1 (ROUNDS=4), same accept edge.
        ky[0] = 8'hA5; ct[0] = 8'hB4; in_valid[0] = 1'b1;
        ky[1] = 8'h00; ct[1] = 8'hE0; in_valid[1] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0; in_valid[1] = 1'b0;
        ct[0] = 8'($urandom); ky[0] = 8'($urandom);
        ct[1] = 8'($urandom); ky[1] = 8'($urandom);
        check("kv4_load", 1, pt[1], 8'h1F);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("kv4_state", 1, pt[1], seq[i]);
            check("kv4_out_valid", 1, 8'(out_valid[1]), 8'(i == 3));
            if (i == 0) begin
                check("kv1_plain", 0, pt[0], 8'h3C);
                check("kv1_out_valid", 0, 8'(out_valid[0]), 8'd1);
            end
        end

        // Backpressure: both lanes stalled in DONE while inputs wiggle.
        for (int c = 0; c < 10; c++) begin
            for (int l = 0; l < 2; l++) begin
                in_valid[l] = 1'($urandom_range(0, 1));
                ct[l]       = 8'($urandom);
                ky[l]       = 8'($urandom);
            end
            @(posedge clk); #1;
        end
        check("bp_hold", 1, pt[1], 8'h00);
        in_valid[0] = 1'b0; in_valid[1] = 1'b0;
        out_ready[0] = 1'b1; out_ready[1] = 1'b1;
        @(posedge clk); #1;
        out_ready[0] = 1'b0; out_ready[1] = 1'b0;
        check("bp_release", 1, 8'(in_ready[1]), 8'd1);
        @(posedge clk); #1;

        // Reset two cycles after accept abandons every lane.
        for (int l = 0; l < NL; l++) begin
            ct[l] = 8'hE0; ky[l] = 8'h00; in_valid[l] = 1'b1;
        end
        @(posedge clk); #1;
        for (int l = 0; l < NL; l++) in_valid[l] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int l = 0; l < NL; l++) out_ready[l] = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        for (int l = 0; l < NL; l++) out_ready[l] = 1'b0;

        ct[1] = 8'hE0; ky[1] = 8'h00; in_valid[1] = 1'b1;
        @(posedge clk); #1;
        in_valid[1] = 1'b0;
        bound = 0;
        ok    = 1'b0;
        while (!ok && bound < 20) begin
            @(posedge clk); #1;
            ok = out_valid[1];
            bound++;
        end
        check("fresh_latency", 1, 8'(bound), 8'd4);
        check("fresh_plain", 1, pt[1], 8'h00);
        out_ready[1] = 1'b1;
        @(posedge clk); #1;
        out_ready[1] = 1'b0;

        // Randomised round-trip streams on all four lanes in parallel.
        rand_mode = 1'b1;
        fork
            lane_random(0);
            lane_random(1);
            lane_random(2);
            lane_random(3);
        join
        rand_mode = 1'b0;
        repeat (3) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
